// File: rtl/cpu7_mem_arb_if.sv
// Bus bundle between the fetch path, the load/store unit, the arbiter and the memory port.
// The slave modport is the arbiter's view; master is the view of the surrounding requesters and memory.
interface cpu7_mem_arb_if;
  logic         ifu_req;
  logic [31:0]  ifu_addr;
  logic         ifu_cancel;
  logic         ifu_addr_ok;
  logic         ifu_valid;
  logic [127:0] ifu_rdata;
  logic         ifu_ex;

  logic         lsu_req;
  logic         lsu_wr;
  logic [3:0]   lsu_wstrb;
  logic [31:0]  lsu_addr;
  logic [31:0]  lsu_wdata;
  logic         lsu_addr_ok;
  logic         lsu_valid;
  logic [31:0]  lsu_rdata;
  logic         lsu_ex;

  logic         mem_req;
  logic         mem_wr;
  logic [3:0]   mem_wstrb;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_addr_ok;
  logic         mem_valid;
  logic [127:0] mem_rdata;
  logic         mem_err;

  modport slave (
    input  ifu_req, ifu_addr, ifu_cancel,
    output ifu_addr_ok, ifu_valid, ifu_rdata, ifu_ex,
    input  lsu_req, lsu_wr, lsu_wstrb, lsu_addr, lsu_wdata,
    output lsu_addr_ok, lsu_valid, lsu_rdata, lsu_ex,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_valid, mem_rdata, mem_err
  );

  modport master (
    output ifu_req, ifu_addr, ifu_cancel,
    input  ifu_addr_ok, ifu_valid, ifu_rdata, ifu_ex,
    output lsu_req, lsu_wr, lsu_wstrb, lsu_addr, lsu_wdata,
    input  lsu_addr_ok, lsu_valid, lsu_rdata, lsu_ex,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_valid, mem_rdata, mem_err
  );
endinterface

// File: rtl/cpu7_mem_arb.sv
// Two-requester memory arbiter: LSU priority with a starvation limit for fetch,
// one outstanding transaction, and absorption of cancelled fetch responses.
module cpu7_mem_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  cpu7_mem_arb_if.slave bus
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_I  = 3'd1,
    REQ_D  = 3'd2,
    WAIT_I = 3'd3,
    WAIT_D = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] starve_q, starve_d;
  logic       drop_q, drop_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= 3'd0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    starve_d        = starve_q;
    drop_d          = drop_q;

    bus.ifu_addr_ok = 1'b0;
    bus.ifu_valid   = 1'b0;
    bus.ifu_rdata   = 128'd0;
    bus.ifu_ex      = 1'b0;
    bus.lsu_addr_ok = 1'b0;
    bus.lsu_valid   = 1'b0;
    bus.lsu_rdata   = 32'd0;
    bus.lsu_ex      = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_wstrb   = 4'd0;
    bus.mem_addr    = 32'd0;
    bus.mem_wdata   = 32'd0;

    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        // A contested LSU grant is only possible below the limit, so +1 saturates at LIMIT.
        if (bus.lsu_req && (!bus.ifu_req || (starve_q != LIMIT))) begin
          state_d  = REQ_D;
          starve_d = bus.ifu_req ? (starve_q + 3'd1) : 3'd0;
        end else if (bus.ifu_req) begin
          state_d  = REQ_I;
          starve_d = 3'd0;
        end
      end

      REQ_I: begin
        bus.mem_req     = 1'b1;
        bus.mem_addr    = bus.ifu_addr;
        bus.ifu_addr_ok = bus.mem_addr_ok;
        if (bus.ifu_cancel) begin
          drop_d = 1'b1;
        end
        if (bus.mem_addr_ok) begin
          state_d = WAIT_I;
        end
      end

      REQ_D: begin
        bus.mem_req     = 1'b1;
        bus.mem_wr      = bus.lsu_wr;
        bus.mem_wstrb   = bus.lsu_wstrb;
        bus.mem_addr    = bus.lsu_addr;
        bus.mem_wdata   = bus.lsu_wdata;
        bus.lsu_addr_ok = bus.mem_addr_ok;
        if (bus.mem_addr_ok) begin
          state_d = WAIT_D;
        end
      end

      WAIT_I: begin
        if (bus.mem_valid) begin
          // A cancel coinciding with the beat suppresses it just like an earlier one.
          bus.ifu_valid = !(drop_q || bus.ifu_cancel);
          if (bus.ifu_valid) begin
            bus.ifu_rdata = bus.mem_rdata;
            bus.ifu_ex    = bus.mem_err;
          end
          drop_d  = 1'b0;
          state_d = IDLE;
        end else if (bus.ifu_cancel) begin
          drop_d = 1'b1;
        end
      end

      WAIT_D: begin
        if (bus.mem_valid) begin
          bus.lsu_valid = 1'b1;
          bus.lsu_rdata = bus.mem_rdata[31:0];
          bus.lsu_ex    = bus.mem_err;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu7_mem_arb.sv
// Directed bench for cpu7_mem_arb: a reactive memory model, a response scoreboard
// filled at each address handshake, and grant-order / latency / cancel / reset checks.
module tb_cpu7_mem_arb;

  localparam int LIM = 4;

  logic clock;
  logic reset;

  cpu7_mem_arb_if bus ();

  cpu7_mem_arb #(.STARVE_LIMIT(LIM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [127:0] rdata;
    logic         ex;
  } exp_t;

  exp_t       ifu_exp[$];
  exp_t       lsu_exp[$];
  logic [7:0] grant_log[$];

  int checks;
  int passes;
  int cyc_n;
  int ifu_ok_cyc, ifu_v_cyc, lsu_ok_cyc, lsu_v_cyc;
  int ifu_v_cnt, lsu_v_cnt;
  bit ifu_ok_seen, lsu_ok_seen;
  int ok_delay, v_delay;
  bit resp_pend;

  function automatic logic [127:0] mem_f(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5555_5555, a ^ 32'hC2AD_BEEF};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory model: addr_ok after ok_delay REQ cycles, response v_delay cycles later.
  initial begin : responder
    int okc;
    int vc;
    logic [31:0] ra;
    okc = 0;
    vc = 0;
    ra = 32'd0;
    resp_pend = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 128'd0;
    bus.mem_err = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      bus.mem_addr_ok = 1'b0;
      bus.mem_valid = 1'b0;
      bus.mem_rdata = 128'd0;
      bus.mem_err = 1'b0;
      if (reset) begin
        resp_pend = 1'b0;
        okc = 0;
      end else if (resp_pend) begin
        if (vc <= 1) begin
          bus.mem_valid = 1'b1;
          bus.mem_rdata = mem_f(ra);
          bus.mem_err = ra[3];
          resp_pend = 1'b0;
        end else begin
          vc--;
        end
      end else if (bus.mem_req) begin
        if (okc >= ok_delay) begin
          bus.mem_addr_ok = 1'b1;
          ra = bus.mem_addr;
          resp_pend = 1'b1;
          vc = v_delay;
          okc = 0;
        end else begin
          okc++;
        end
      end
    end
  end

  // Scoreboard side: push expectations at the address handshake, pop on response beats.
  initial begin : monitor
    exp_t e;
    logic [127:0] full;
    cyc_n = 0;
    ifu_v_cnt = 0;
    lsu_v_cnt = 0;
    forever begin
      @(posedge clock);
      cyc_n++;
      #3;
      if (bus.ifu_addr_ok) begin
        ifu_ok_seen = 1'b1;
        ifu_ok_cyc = cyc_n;
        grant_log.push_back("I");
        chk("ifu_mem_addr", bus.mem_addr, bus.ifu_addr);
        chk("ifu_mem_wr", bus.mem_wr, 0);
        chk("ifu_mem_wstrb", bus.mem_wstrb, 0);
        chk("ifu_grant_lsu_ok_low", bus.lsu_addr_ok, 0);
        e.rdata = mem_f(bus.ifu_addr);
        e.ex = bus.ifu_addr[3];
        ifu_exp.push_back(e);
      end
      if (bus.lsu_addr_ok) begin
        lsu_ok_seen = 1'b1;
        lsu_ok_cyc = cyc_n;
        grant_log.push_back("D");
        chk("lsu_mem_addr", bus.mem_addr, bus.lsu_addr);
        chk("lsu_mem_wr", bus.mem_wr, bus.lsu_wr);
        chk("lsu_mem_wstrb", bus.mem_wstrb, bus.lsu_wstrb);
        chk("lsu_mem_wdata", bus.mem_wdata, bus.lsu_wdata);
        full = mem_f(bus.lsu_addr);
        e.rdata = {96'd0, full[31:0]};
        e.ex = bus.lsu_addr[3];
        lsu_exp.push_back(e);
      end
      if (bus.ifu_valid) begin
        ifu_v_cnt++;
        ifu_v_cyc = cyc_n;
        if (ifu_exp.size() == 0) begin
          chk("ifu_valid_unexpected", bus.ifu_valid, 0);
        end else begin
          e = ifu_exp.pop_front();
          chk("ifu_rdata", bus.ifu_rdata, e.rdata);
          chk("ifu_ex", bus.ifu_ex, e.ex);
        end
      end
      if (bus.lsu_valid) begin
        lsu_v_cnt++;
        lsu_v_cyc = cyc_n;
        if (lsu_exp.size() == 0) begin
          chk("lsu_valid_unexpected", bus.lsu_valid, 0);
        end else begin
          e = lsu_exp.pop_front();
          chk("lsu_rdata", bus.lsu_rdata, e.rdata);
          chk("lsu_ex", bus.lsu_ex, e.ex);
        end
      end
    end
  end

  task automatic chk_zero(input string t);
    chk({t, "_ctl"}, {bus.mem_req, bus.mem_wr, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata,
                      bus.ifu_addr_ok, bus.ifu_valid, bus.ifu_ex,
                      bus.lsu_addr_ok, bus.lsu_valid, bus.lsu_ex}, 0);
    chk({t, "_ifu_rdata"}, bus.ifu_rdata, 0);
    chk({t, "_lsu_rdata"}, bus.lsu_rdata, 0);
  endtask

  task automatic fetch(input logic [31:0] a);
    int n = 0;
    bus.ifu_addr = a;
    bus.ifu_req = 1'b1;
    ifu_ok_seen = 1'b0;
    while (n < 40 && !ifu_ok_seen) begin
      cyc();
      n++;
    end
    bus.ifu_req = 1'b0;
    chk("ifu_ok_wait", ifu_ok_seen, 1);
  endtask

  task automatic lsu_op(input logic wr, input logic [3:0] strb, input logic [31:0] a,
                        input logic [31:0] d);
    int n = 0;
    bus.lsu_wr = wr;
    bus.lsu_wstrb = strb;
    bus.lsu_addr = a;
    bus.lsu_wdata = d;
    bus.lsu_req = 1'b1;
    lsu_ok_seen = 1'b0;
    while (n < 40 && !lsu_ok_seen) begin
      cyc();
      n++;
    end
    bus.lsu_req = 1'b0;
    chk("lsu_ok_wait", lsu_ok_seen, 1);
  endtask

  task automatic wait_done(input string t);
    int n = 0;
    while (n < 60 && (resp_pend || ifu_exp.size() != 0 || lsu_exp.size() != 0 || bus.mem_req)) begin
      cyc();
      n++;
    end
    chk({t, "_done"}, n < 60, 1);
  endtask

  initial begin : stim
    int c0;
    int v0;
    int g0;
    int n;
    logic [7:0] exp_order [10];
    exp_order = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};
    checks = 0;
    passes = 0;
    ok_delay = 0;
    v_delay = 1;
    reset = 1'b1;
    bus.ifu_req = 1'b0;
    bus.ifu_addr = 32'd0;
    bus.ifu_cancel = 1'b0;
    bus.lsu_req = 1'b0;
    bus.lsu_wr = 1'b0;
    bus.lsu_wstrb = 4'd0;
    bus.lsu_addr = 32'd0;
    bus.lsu_wdata = 32'd0;
    cyc();
    cyc();
    chk_zero("reset");
    reset = 1'b0;
    cyc();

    // Single fetch, minimum turnaround; an LSU read queued in WAIT_I shows IDLE in cycle 3.
    c0 = cyc_n;
    fetch(32'h1c00_0000);
    chk("f1_addr_ok_cycle", ifu_ok_cyc - c0, 1);
    lsu_op(1'b0, 4'h0, 32'h0000_0104, 32'd0);
    chk("f1_valid_cycle", ifu_v_cyc - c0, 2);
    chk("f1_next_grant_cycle", lsu_ok_cyc - c0, 4);
    wait_done("f1");

    // LSU write: fields mirrored, response aligned with mem_valid, fetch side silent.
    v0 = ifu_v_cnt;
    g0 = grant_log.size();
    lsu_op(1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678);
    wait_done("wr");
    chk("wr_ifu_quiet", ifu_v_cnt, v0);
    chk("wr_grant_kind", grant_log[g0], "D");
    chk("wr_grant_count", grant_log.size() - g0, 1);
    chk("wr_valid_cycle", lsu_v_cyc - lsu_ok_cyc, 1);

    // Further data patterns, including an error response, and a faulting fetch.
    lsu_op(1'b0, 4'h0, 32'h0000_0108, 32'd0);
    wait_done("rd_err");
    lsu_op(1'b1, 4'h3, 32'h0000_020C, 32'hCAFE_F00D);
    wait_done("wr_half");
    fetch(32'h1c00_0008);
    wait_done("f_err");
    lsu_op(1'b0, 4'h0, 32'h0000_0010, 32'd0);
    wait_done("rd_plain");

    // Continuous contention: starvation limit forces every fifth grant to fetch.
    grant_log.delete();
    bus.ifu_addr = 32'h0000_2000;
    bus.lsu_wr = 1'b0;
    bus.lsu_wstrb = 4'h0;
    bus.lsu_addr = 32'h0000_0300;
    bus.lsu_wdata = 32'd0;
    bus.ifu_req = 1'b1;
    bus.lsu_req = 1'b1;
    n = 0;
    while (n < 200 && grant_log.size() < 10) begin
      cyc();
      n++;
    end
    bus.ifu_req = 1'b0;
    bus.lsu_req = 1'b0;
    chk("cont_grants_made", grant_log.size() >= 10, 1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("cont_grant_%0d", i), grant_log[i], exp_order[i]);
    end
    wait_done("cont");

    // Cancel in WAIT_I one cycle before the beat.
    v_delay = 3;
    fetch(32'h1c00_0040);
    cyc();
    bus.ifu_cancel = 1'b1;
    ifu_exp.delete();
    v0 = ifu_v_cnt;
    cyc();
    bus.ifu_cancel = 1'b0;
    wait_done("cw");
    chk("cw_dropped", ifu_v_cnt, v0);
    v_delay = 1;
    fetch(32'h1c00_0080);
    wait_done("cw_next");
    chk("cw_next_delivered", ifu_v_cnt, v0 + 1);

    // Cancel in the same cycle as the beat.
    v_delay = 2;
    fetch(32'h1c00_0090);
    cyc();
    bus.ifu_cancel = 1'b1;
    ifu_exp.delete();
    v0 = ifu_v_cnt;
    cyc();
    bus.ifu_cancel = 1'b0;
    wait_done("cs");
    chk("cs_dropped", ifu_v_cnt, v0);
    v_delay = 1;

    // Cancel in REQ_I with a slow address phase: request held, response absorbed.
    ok_delay = 3;
    v0 = ifu_v_cnt;
    bus.ifu_addr = 32'h1c00_00C0;
    bus.ifu_req = 1'b1;
    ifu_ok_seen = 1'b0;
    cyc();
    c0 = cyc_n;
    chk("cr_mem_req_0", bus.mem_req, 1);
    cyc();
    bus.ifu_cancel = 1'b1;
    chk("cr_mem_req_1", bus.mem_req, 1);
    cyc();
    bus.ifu_cancel = 1'b0;
    chk("cr_mem_req_2", bus.mem_req, 1);
    cyc();
    chk("cr_mem_req_3", bus.mem_req, 1);
    n = 0;
    while (n < 20 && !ifu_ok_seen) begin
      cyc();
      n++;
    end
    bus.ifu_req = 1'b0;
    ifu_exp.delete();
    chk("cr_addr_ok_cycle", ifu_ok_cyc - c0, 3);
    ok_delay = 0;
    wait_done("cr");
    chk("cr_dropped", ifu_v_cnt, v0);

    // Cancel while idle has no effect on the following fetch.
    bus.ifu_cancel = 1'b1;
    cyc();
    bus.ifu_cancel = 1'b0;
    fetch(32'h1c00_0100);
    wait_done("ci");
    chk("ci_delivered", ifu_v_cnt, v0 + 1);

    // Reset in WAIT_D with the LSU request still pending.
    v_delay = 5;
    bus.lsu_wr = 1'b0;
    bus.lsu_wstrb = 4'h0;
    bus.lsu_addr = 32'h0000_0400;
    bus.lsu_wdata = 32'd0;
    bus.lsu_req = 1'b1;
    lsu_ok_seen = 1'b0;
    n = 0;
    while (n < 20 && !lsu_ok_seen) begin
      cyc();
      n++;
    end
    chk("rw_first_grant", lsu_ok_seen, 1);
    reset = 1'b1;
    lsu_exp.delete();
    v0 = lsu_v_cnt;
    cyc();
    chk_zero("rw_reset");
    reset = 1'b0;
    v_delay = 1;
    lsu_ok_seen = 1'b0;
    n = 0;
    while (n < 20 && !lsu_ok_seen) begin
      cyc();
      n++;
    end
    bus.lsu_req = 1'b0;
    chk("rw_regrant", lsu_ok_seen, 1);
    wait_done("rw");
    chk("rw_one_response", lsu_v_cnt, v0 + 1);

    cyc();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
